// File: rtl/bist_fsm_if.sv
// Signal bundle between the TAP-side test environment and the RUNBIST controller.
// The master side drives control, memory data and CUT response; the slave side is bist_fsm.
interface bist_fsm_if;
  logic        runbist_en;
  logic        idle_en;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic [7:0]  mem_data;
  logic        read_mem;
  logic [7:0]  addr;
  logic [4:0]  impact;
  logic [3:0]  result;
  logic [13:0] signature;

  modport master (
    output runbist_en, idle_en, start_addr, end_addr, mem_data, result,
    input  read_mem, addr, impact, signature
  );

  modport slave (
    input  runbist_en, idle_en, start_addr, end_addr, mem_data, result,
    output read_mem, addr, impact, signature
  );
endinterface

// File: rtl/bist_fsm.sv
// RUNBIST controller: walks a vector-memory window, drives each vector into the CUT
// and compacts vector plus response into a 14-bit MISR signature.
module bist_fsm (
  input  logic       clk,
  input  logic       rst_n,
  bist_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  addr_q;
  logic [4:0]  impact_q;
  logic [13:0] sig_q;
  logic [7:0]  vec_q;
  logic [13:0] misr_in;
  logic [13:0] sig_d;

  // Polynomial x^14+x^5+x^3+x+1: the feedback bit s[13] folds into taps 0, 1, 3 and 5.
  function automatic logic [13:0] misr_next(input logic [13:0] s, input logic [13:0] din);
    logic [13:0] n;
    n[0] = s[13] ^ din[0];
    for (int i = 1; i < 14; i++) begin
      n[i] = s[i-1] ^ din[i];
    end
    n[1] = n[1] ^ s[13];
    n[3] = n[3] ^ s[13];
    n[5] = n[5] ^ s[13];
    return n;
  endfunction

  always_comb begin
    misr_in = {vec_q, 2'b00, bus.result};
    sig_d   = misr_next(sig_q, misr_in);
  end

  // A paused test (idle_en low) must not fetch, so the strobe is qualified by both enables.
  assign bus.read_mem  = (state_q == S_READ) && bus.idle_en && bus.runbist_en;
  assign bus.addr      = addr_q;
  assign bus.impact    = impact_q;
  assign bus.signature = sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'h00;
      impact_q <= 5'h00;
      sig_q    <= 14'h0000;
      vec_q    <= 8'h00;
    end else if ((state_q != S_IDLE) && !bus.runbist_en) begin
      // Abort keeps addr, impact and signature so the TAP can still read them.
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.runbist_en && bus.idle_en) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.idle_en) begin
            addr_q  <= bus.start_addr;
            sig_q   <= 14'h0000;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (bus.idle_en) begin
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (bus.idle_en) begin
            vec_q    <= bus.mem_data;
            impact_q <= bus.mem_data[4:0];
            state_q  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (bus.idle_en) begin
            sig_q <= sig_d;
            if (addr_q == bus.end_addr) begin
              state_q <= S_DONE;
            end else begin
              addr_q  <= addr_q + 8'd1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_fsm.sv
// Bench for bist_fsm: random vector memory and CUT table, transaction-level model of
// the address walk and MISR signature, with cycle checks on strobes and pauses.
module tb_bist_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_fsm_if bus ();

  bist_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [3:0] cut_tbl [32];
  logic [7:0] mem_q = 8'h00;
  logic [7:0] exp_addr [$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Vector memory answers one cycle after the strobe; the CUT answers combinationally.
  assign bus.mem_data = mem_q;
  assign bus.result   = cut_tbl[bus.impact];
  always @(posedge clk) if (bus.read_mem) mem_q <= mem[bus.addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] misr_model(input logic [13:0] s, input logic [7:0] v,
                                             input logic [3:0] r);
    logic [13:0] din;
    din = {v, 2'b00, r};
    return (s << 1) ^ din ^ (s[13] ? 14'h002B : 14'h0000);
  endfunction

  task automatic run_window(input string nm, input logic [7:0] s, input logic [7:0] e,
                            input int pause_pct, input int fixed_at, input bit timed,
                            output logic [13:0] final_sig);
    logic [13:0] sig_exp, sig_prev_exp, psig;
    logic [7:0]  pa, paddr;
    logic [4:0]  pimp;
    int n0, k, nv, pause, budget;
    bit fixed_done, pulse;

    exp_addr.delete();
    pa = s;
    exp_addr.push_back(pa);
    while (pa != e) begin
      pa = pa + 8'd1;
      exp_addr.push_back(pa);
    end
    nv = exp_addr.size();
    sig_exp = 14'h0;
    sig_prev_exp = 14'h0;
    for (int i = 0; i < nv; i++) begin
      sig_prev_exp = sig_exp;
      sig_exp = misr_model(sig_exp, mem[exp_addr[i]], cut_tbl[mem[exp_addr[i]][4:0]]);
    end

    @(negedge clk);
    bus.start_addr = s;
    bus.end_addr   = e;
    bus.runbist_en = 1'b1;
    bus.idle_en    = 1'b1;
    n0 = cyc;
    k = 0; pause = 0; fixed_done = 0;
    psig = bus.signature; paddr = bus.addr; pimp = bus.impact;
    budget = 12 * nv + 40;

    while (k < nv && budget > 0) begin
      @(negedge clk);
      budget--;
      pulse = 0;
      if (!bus.idle_en) begin
        chk({nm, " rd_paused"}, bus.read_mem, 1'b0);
        chk({nm, " sig_frozen"}, bus.signature, psig);
        chk({nm, " addr_frozen"}, bus.addr, paddr);
        chk({nm, " imp_frozen"}, bus.impact, pimp);
      end else if (bus.read_mem) begin
        pulse = 1;
        chk({nm, " rd_addr"}, bus.addr, exp_addr[k]);
        if (timed) chk({nm, " rd_cycle"}, cyc, n0 + 2 + 3 * k);
        if (k == 0) chk({nm, " load_clr"}, bus.signature, 14'h0);
        else chk({nm, " impact"}, bus.impact, mem[exp_addr[k-1]][4:0]);
        k++;
      end
      psig = bus.signature; paddr = bus.addr; pimp = bus.impact;
      if (pulse) begin
        bus.idle_en = 1'b1;
      end else begin
        if (k == fixed_at && !fixed_done) begin
          fixed_done = 1;
          pause = 5;
        end
        if (pause > 0) begin
          bus.idle_en = 1'b0;
          pause--;
        end else begin
          bus.idle_en = ($urandom_range(99) < pause_pct) ? 1'b0 : 1'b1;
        end
      end
    end
    if (k < nv) chk({nm, " timeout_pulses"}, k, nv);
    bus.idle_en = 1'b1;

    repeat (2) @(negedge clk);
    chk({nm, " sig_before_last"}, bus.signature, sig_prev_exp);
    @(negedge clk);
    chk({nm, " sig_done"}, bus.signature, sig_exp);
    chk({nm, " imp_done"}, bus.impact, mem[exp_addr[nv-1]][4:0]);
    chk({nm, " addr_done"}, bus.addr, e);
    if (timed) chk({nm, " done_cycle"}, cyc, n0 + 2 + 3 * nv);
    repeat (4) begin
      @(negedge clk);
      chk({nm, " done_no_rd"}, bus.read_mem, 1'b0);
      chk({nm, " done_hold"}, bus.signature, sig_exp);
    end
    final_sig = bus.signature;
  endtask

  task automatic leave_done();
    @(negedge clk);
    bus.runbist_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [13:0] sig_plain, sig_pause, sig_tmp, hs;
    logic [7:0]  ha;
    logic [4:0]  hi;
    logic [7:0]  rs;
    int n0;

    bus.runbist_en = 1'b0; bus.idle_en = 1'b0;
    bus.start_addr = 8'h00; bus.end_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) cut_tbl[i] = 4'($urandom);

    #1;
    chk("rst_addr", bus.addr, 8'h00);
    chk("rst_impact", bus.impact, 5'h00);
    chk("rst_sig", bus.signature, 14'h0);
    chk("rst_rd", bus.read_mem, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mem[8'h03] = 8'hAB;
    cut_tbl[5'h0B] = 4'hC;
    run_window("single", 8'h03, 8'h03, 0, -1, 1'b1, sig_tmp);
    chk("single_sig_const", sig_tmp, 14'h2ACC);
    leave_done();

    run_window("walk", 8'd3, 8'd10, 0, -1, 1'b1, sig_plain);
    leave_done();

    run_window("pause", 8'd3, 8'd10, 0, 4, 1'b0, sig_pause);
    chk("pause_vs_plain", sig_pause, sig_plain);
    leave_done();

    // Abort after a few vectors, then restart the same window.
    @(negedge clk);
    bus.start_addr = 8'd3; bus.end_addr = 8'd10;
    bus.runbist_en = 1'b1; bus.idle_en = 1'b1;
    n0 = cyc;
    while (cyc < n0 + 12) @(negedge clk);
    hs = bus.signature; ha = bus.addr; hi = bus.impact;
    bus.runbist_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rd", bus.read_mem, 1'b0);
      chk("abort_sig", bus.signature, hs);
      chk("abort_addr", bus.addr, ha);
      chk("abort_imp", bus.impact, hi);
    end
    run_window("restart", 8'd3, 8'd10, 0, -1, 1'b1, sig_tmp);
    chk("restart_vs_plain", sig_tmp, sig_plain);
    leave_done();

    run_window("wrap", 8'hFE, 8'h01, 0, -1, 1'b1, sig_tmp);
    leave_done();

    // Asynchronous reset in the middle of a run, away from any clock edge.
    @(negedge clk);
    bus.start_addr = 8'd20; bus.end_addr = 8'd30;
    bus.runbist_en = 1'b1; bus.idle_en = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", bus.addr, 8'h00);
    chk("arst_impact", bus.impact, 5'h00);
    chk("arst_sig", bus.signature, 14'h0);
    chk("arst_rd", bus.read_mem, 1'b0);
    @(negedge clk);
    bus.runbist_en = 1'b0;
    rst_n = 1'b1;
    run_window("post_rst", 8'd20, 8'd30, 0, -1, 1'b1, sig_tmp);
    leave_done();

    for (int t = 0; t < 20; t++) begin
      rs = 8'($urandom);
      run_window("rand", rs, rs + 8'($urandom_range(15)), 25, -1, 1'b0, sig_tmp);
      leave_done();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
